instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Upstream program loader for the instruction memory.
- Takes the byte stream from the debug UART receiver, packs bytes into 32-bit big-endian words, and issues one write per word.
- Each write presents a word address, an instruction and a one-cycle write-flag pulse.
- Loading stops on the HALT word or on memory overflow, and the block reports done or error to the debug unit.

Parameters:
- SIZE_ADDR_PC, 32, width of the instruction word and of the word address.
- TOTAL_SIZE, 256, instruction memory depth in words.
- SIZE_BYTE, 8, width of the UART data byte.
- HALT_WORD, 32'hFFFFFFFF, terminating instruction; it is also written to memory.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  single-cycle request to begin a load.
- i_rx_data  in  SIZE_BYTE  received byte.
- i_rx_valid  in  1  i_rx_data is valid this cycle (one-cycle strobe).
- o_ready  out  1  high in RECV; bytes are accepted only when o_ready is high.
- o_instruction_address  out  SIZE_ADDR_PC  word address of the current write.
- o_instruction  out  SIZE_ADDR_PC  assembled instruction.
- o_flag_write_instruc  out  1  one-cycle write pulse.
- o_words_loaded  out  SIZE_ADDR_PC  count of words written in the current load.
- o_load_done  out  1  level; HALT word has been written.
- o_load_error  out  1  level; memory full before HALT.

Behaviour:
- Reset (i_reset low, asynchronous): state IDLE; all outputs 0; byte counter 0; shift register 0.
- States: IDLE, RECV, WRITE, DONE, ERROR.
- IDLE:
  - i_start -> RECV next cycle; address, byte counter and o_words_loaded cleared.
  - o_load_done and o_load_error cleared.
- RECV (o_ready=1):
  - On each i_rx_valid, shift register = {shreg[23:0], i_rx_data]; the first byte ends in bits [31:24].
  - After the 4th byte: o_instruction takes the full word on that same edge, state -> WRITE, byte counter -> 0.
  - i_start is ignored in RECV.
- WRITE (one cycle):
  - o_flag_write_instruc=1 for exactly this cycle.
  - o_instruction and o_instruction_address are already stable from the previous edge. This gives the memory setup before it captures on the flag's rising edge.
  - o_words_loaded increments at the end of the cycle.
  - Next state priority:
    - word == HALT_WORD -> DONE.
    - else address == TOTAL_SIZE-1 -> ERROR.
    - else address+1, -> RECV.
- Latency: 4th byte edge to flag high is 1 cycle. o_instruction and o_instruction_address hold their values until the next word is assembled.
- DONE / ERROR: the respective flag is held high; i_start -> RECV with the same clearing as in IDLE.
- Bytes arriving with o_ready=0 (IDLE, WRITE, DONE, ERROR) are dropped without side effects.
- Partial word at reset: discarded. Memory contents already written are not undone.
- Address arithmetic: unsigned; it never wraps, because overflow goes to ERROR first.
- i_rx_valid and i_start in the same cycle in IDLE: start only; the byte is dropped.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of every accepted byte is kept.
  - After the HALT write, the FSM enters CHECK (o_ready=1) and accepts one more byte.
  - Byte equal to the running XOR -> DONE; otherwise -> ERROR.
  - The checksum byte is not included in the XOR.
- Undefined: no CHECK state; HALT write goes directly to DONE.

Decomposition:
- Shared package mips_pkg holds:
  - the loader state enum;
  - HALT_WORD, SIZE_BYTE and SIZE_ADDR_PC constants;
  - BYTES_PER_WORD = 4.
- Natural sub-module: byte_packer. It contains the shift register and the 2-bit byte counter, takes byte plus valid, and outputs the word plus a word_ready pulse. The FSM stays in instr_loader.

Test Plan:
- Reset mid-word: start, send 8C, 01 (2 bytes), pull i_reset low, then start again and send 20,08,00,05 -> address 0 gets 32'h20080005; the first partial word is never written.
- Normal load: start, send bytes 20,08,00,05 then FF,FF,FF,FF.
  - Flag pulses with addr 0 / 32'h20080005, then addr 1 / 32'hFFFFFFFF.
  - o_words_loaded=2, o_load_done=1.
- Overflow with TOTAL_SIZE=4: send 4 non-HALT words -> 4 flag pulses (addr 0..3), o_load_error=1. A 5th word's bytes are dropped and no flag is issued.
- Dropped bytes: i_rx_valid pulses in IDLE and during WRITE -> no shift and no flag. The next load's first word is unaffected.
- Restart after DONE: i_start -> flags cleared, address 0; new word 32'h00000000 is written at addr 0.
- LOADER_CHECKSUM_EN:
  - HALT-only load followed by checksum 00 -> DONE (XOR of FF×4 = 00).
  - Same load followed by 5A -> ERROR.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction program loader.
// Package mips_pkg: loader state enum, word/byte widths, HALT word.
package mips_pkg;

  localparam int SIZE_ADDR_PC   = 32;
  localparam int SIZE_BYTE      = 8;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [SIZE_ADDR_PC-1:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4,
    S_CHECK = 3'd5
  } ld_state_e;

endpackage

// File: rtl/instr_loader_if.sv
// UART-side byte stream and memory-side write bus of the loader.
// master: loader side; slave: UART receiver / instruction memory side.
interface instr_loader_if #(
  parameter int SIZE_ADDR_PC = mips_pkg::SIZE_ADDR_PC,
  parameter int SIZE_BYTE    = mips_pkg::SIZE_BYTE
);

  logic [SIZE_BYTE-1:0]    i_rx_data;
  logic                    i_rx_valid;
  logic                    o_ready;
  logic [SIZE_ADDR_PC-1:0] o_instruction_address;
  logic [SIZE_ADDR_PC-1:0] o_instruction;
  logic                    o_flag_write_instruc;

  modport master (
    input  i_rx_data,
    input  i_rx_valid,
    output o_ready,
    output o_instruction_address,
    output o_instruction,
    output o_flag_write_instruc
  );

  modport slave (
    output i_rx_data,
    output i_rx_valid,
    input  o_ready,
    input  o_instruction_address,
    input  o_instruction,
    input  o_flag_write_instruc
  );

endinterface

// File: rtl/instr_loader_byte_packer.sv
// Packs accepted bytes big-endian into words; o_word_ready pulses
// combinationally with the 4th byte. Ports: clk, rst, clear, byte+valid.
module byte_packer
  import mips_pkg::*;
#(
  parameter int SIZE_WORD = SIZE_ADDR_PC,
  parameter int SB        = SIZE_BYTE
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_valid,
  input  logic [SB-1:0]        i_data,
  output logic [SIZE_WORD-1:0] o_word,
  output logic                 o_word_ready
);

  localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);

  // Only the three newest bytes need storing; the 4th is live input.
  logic [SIZE_WORD-SB-1:0] r_shreg;
  logic [1:0]              r_cnt;

  assign o_word       = {r_shreg, i_data};
  assign o_word_ready = i_valid & (r_cnt == LAST);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (i_clear) begin
      r_cnt   <= '0;
    end else if (i_valid) begin
      r_shreg <= o_word[SIZE_WORD-SB-1:0];
      r_cnt   <= r_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Program loader: UART bytes -> 32-bit words -> instruction memory writes.
// Ports: i_clk, i_reset(async low), i_start, bus (instr_loader_if.master),
// o_words_loaded, o_load_done, o_load_error. Option: LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int SIZE_ADDR_PC = mips_pkg::SIZE_ADDR_PC,
  parameter int TOTAL_SIZE   = 256,
  parameter int SIZE_BYTE    = mips_pkg::SIZE_BYTE,
  parameter logic [SIZE_ADDR_PC-1:0] HALT_WORD = mips_pkg::HALT_WORD
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  instr_loader_if.master          bus,
  output logic [SIZE_ADDR_PC-1:0] o_words_loaded,
  output logic                    o_load_done,
  output logic                    o_load_error
);

  import mips_pkg::*;

  localparam logic [2:0] ST_IDLE  = S_IDLE;
  localparam logic [2:0] ST_RECV  = S_RECV;
  localparam logic [2:0] ST_WRITE = S_WRITE;
  localparam logic [2:0] ST_DONE  = S_DONE;
  localparam logic [2:0] ST_ERROR = S_ERROR;
  localparam logic [2:0] ST_CHECK = S_CHECK;

  localparam logic [SIZE_ADDR_PC-1:0] LAST_ADDR =
    SIZE_ADDR_PC'(TOTAL_SIZE - 1);
  localparam logic [SIZE_ADDR_PC-1:0] ONE = SIZE_ADDR_PC'(1);

`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_HALTED = ST_CHECK;
`else
  localparam logic [2:0] ST_HALTED = ST_DONE;
`endif

  logic [2:0]              r_state;
  logic [SIZE_ADDR_PC-1:0] r_addr;
  logic [SIZE_ADDR_PC-1:0] r_instr;
  logic [SIZE_ADDR_PC-1:0] r_words;

  logic [SIZE_ADDR_PC-1:0] w_word;
  logic                    w_word_ready;
  logic                    w_accept;
  logic                    w_clear;

  assign w_accept = bus.i_rx_valid & (r_state == ST_RECV);
  assign w_clear  = i_start & ((r_state == ST_IDLE) |
                               (r_state == ST_DONE) |
                               (r_state == ST_ERROR));

  byte_packer #(
    .SIZE_WORD (SIZE_ADDR_PC),
    .SB        (SIZE_BYTE)
  ) u_packer (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (w_clear),
    .i_valid      (w_accept),
    .i_data       (bus.i_rx_data),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [SIZE_BYTE-1:0] r_xor;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)      r_xor <= '0;
    else if (w_clear)  r_xor <= '0;
    else if (w_accept) r_xor <= r_xor ^ bus.i_rx_data;
  end

  assign bus.o_ready = (r_state == ST_RECV) | (r_state == ST_CHECK);
`else
  assign bus.o_ready = (r_state == ST_RECV);
`endif

  assign bus.o_instruction_address = r_addr;
  assign bus.o_instruction         = r_instr;
  assign bus.o_flag_write_instruc  = (r_state == ST_WRITE);
  assign o_words_loaded            = r_words;
  assign o_load_done               = (r_state == ST_DONE);
  assign o_load_error              = (r_state == ST_ERROR);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_instr <= '0;
      r_words <= '0;
    end else begin
      case (r_state)
        ST_RECV: begin
          if (w_word_ready) begin
            r_instr <= w_word;
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          r_words <= r_words + ONE;
          if (r_instr == HALT_WORD) begin
            r_state <= ST_HALTED;
          end else if (r_addr == LAST_ADDR) begin
            r_state <= ST_ERROR;
          end else begin
            r_addr  <= r_addr + ONE;
            r_state <= ST_RECV;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (bus.i_rx_valid) begin
            r_state <= (bus.i_rx_data == r_xor) ? ST_DONE : ST_ERROR;
          end
        end
`endif
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (i_start) begin
            r_state <= ST_RECV;
            r_addr  <= '0;
            r_words <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader (TOTAL_SIZE = 4).
// Directed sequences, a vector table and randomized loads vs a model.
module tb_instr_loader;

  localparam int          TS   = 4;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] wl;
  logic        done;
  logic        err;

  instr_loader_if bus ();

  instr_loader #(
    .TOTAL_SIZE (TS)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_start        (start),
    .bus            (bus),
    .o_words_loaded (wl),
    .o_load_done    (done),
    .o_load_error   (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t cap[$];

  always @(negedge clk)
    if (bus.o_flag_write_instruc === 1'b1)
      cap.push_back({bus.o_instruction_address, bus.o_instruction});

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xor4(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic send_halt(input logic [7:0] ck);
    send_word(HALT, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(ck, 0);
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[4];

  initial begin
    bus.i_rx_data  = '0;
    bus.i_rx_valid = 1'b0;

    tbl[0] = '{8'h12, 8'h34, 8'h56, 8'h78, 32'h1234_5678};
    tbl[1] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hDEAD_BEEF};
    tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFE, 32'hFFFF_FFFE};
    tbl[3] = '{8'h80, 8'h00, 8'h00, 8'h01, 32'h8000_0001};

    // reset state
    @(negedge clk);
    chk("rst_ready", bus.o_ready, 0);
    chk("rst_flag", bus.o_flag_write_instruc, 0);
    chk("rst_addr", bus.o_instruction_address, 0);
    chk("rst_instr", bus.o_instruction, 0);
    chk("rst_words", wl, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;

    // reset mid-word discards the partial word
    pulse_start();
    send_byte(8'h8C, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_ready", bus.o_ready, 0);
    cap.delete();
    pulse_start();
    send_word(32'h2008_0005, 1);
    send_halt(xor4(32'h2008_0005));
    settle();
    chk("midrst_n", cap.size(), 2);
    chk("midrst_a0", cap[0].a, 0);
    chk("midrst_d0", cap[0].d, 32'h2008_0005);
    chk("midrst_done", done, 1);

    // normal load with latency check
    cap.delete();
    pulse_start();
    chk("start_done_clr", done, 0);
    send_byte(8'h20, 0);
    send_byte(8'h08, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    bus.i_rx_data  = 8'h05;
    bus.i_rx_valid = 1'b1;
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
    chk("lat_flag", bus.o_flag_write_instruc, 1);
    chk("lat_addr", bus.o_instruction_address, 0);
    chk("lat_instr", bus.o_instruction, 32'h2008_0005);
    send_halt(xor4(32'h2008_0005));
    settle();
    chk("norm_n", cap.size(), 2);
    chk("norm_a1", cap[1].a, 1);
    chk("norm_d1", cap[1].d, HALT);
    chk("norm_words", wl, 2);
    chk("norm_done", done, 1);
    chk("norm_err", err, 0);

    // overflow: 4 non-HALT words fill memory
    cap.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) send_word(32'h0000_0100 + i, 0);
    settle();
    chk("ovf_n", cap.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < cap.size()) chk("ovf_addr", cap[i].a, i);
    end
    chk("ovf_err", err, 1);
    chk("ovf_words", wl, 4);
    send_word(32'h1234_5678, 0);
    settle();
    chk("ovf_drop_n", cap.size(), 4);
    chk("ovf_ready", bus.o_ready, 0);

    // dropped bytes: idle, start+valid, during WRITE
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cap.delete();
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    @(negedge clk);
    start          = 1'b1;
    bus.i_rx_data  = 8'hCC;
    bus.i_rx_valid = 1'b1;
    @(negedge clk);
    start          = 1'b0;
    bus.i_rx_valid = 1'b0;
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    @(negedge clk);
    bus.i_rx_data  = 8'h44;
    bus.i_rx_valid = 1'b1;
    @(negedge clk);
    bus.i_rx_data  = 8'h99;
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
    send_word(32'h5566_7788, 0);
    send_halt(xor4(32'h1122_3344) ^ xor4(32'h5566_7788));
    settle();
    chk("drop_n", cap.size(), 3);
    chk("drop_d0", cap[0].d, 32'h1122_3344);
    chk("drop_a1", cap[1].a, 1);
    chk("drop_d1", cap[1].d, 32'h5566_7788);
    chk("drop_words", wl, 3);
    chk("drop_done", done, 1);

    // restart after DONE
    cap.delete();
    pulse_start();
    chk("rs_done", done, 0);
    chk("rs_err", err, 0);
    chk("rs_addr", bus.o_instruction_address, 0);
    chk("rs_words", wl, 0);
    send_word(32'h0, 0);
    send_halt(8'h00);
    settle();
    chk("rs_a0", cap[0].a, 0);
    chk("rs_d0", cap[0].d, 32'h0);
    chk("rs_done2", done, 1);

    // vector table: one word then HALT
    for (int i = 0; i < 4; i++) begin
      cap.delete();
      pulse_start();
      send_byte(tbl[i].b0, 0);
      send_byte(tbl[i].b1, 0);
      send_byte(tbl[i].b2, 0);
      send_byte(tbl[i].b3, 0);
      send_halt(tbl[i].b0 ^ tbl[i].b1 ^ tbl[i].b2 ^ tbl[i].b3);
      settle();
      chk("tbl_d0", cap[0].d, tbl[i].exp);
      chk("tbl_a0", cap[0].a, 0);
      chk("tbl_done", done, 1);
    end

`ifdef LOADER_CHECKSUM_EN
    cap.delete();
    pulse_start();
    send_word(HALT, 0);
    @(negedge clk);
    chk("ck_ready", bus.o_ready, 1);
    chk("ck_wait_done", done, 0);
    send_byte(8'h00, 0);
    settle();
    chk("ck_ok_done", done, 1);
    pulse_start();
    send_word(HALT, 0);
    send_byte(8'h5A, 0);
    settle();
    chk("ck_bad_err", err, 1);
    chk("ck_bad_done", done, 0);
`endif

    // randomized loads against a word-level model
    for (int t = 0; t < 40; t++) begin
      logic [31:0] ws[$];
      wr_t         exp[$];
      int          n;
      int          addr;
      bit          ended;
      bit          mdone;
      bit          merr;
      logic [7:0]  x;
      logic [31:0] w;
      ws.delete();
      exp.delete();
      addr  = 0;
      ended = 0;
      mdone = 0;
      merr  = 0;
      x     = 8'h00;
      n     = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        w = ($urandom_range(0, 3) == 0) ? HALT : $urandom;
        if (i == n - 1 && n < 5) w = HALT;
        ws.push_back(w);
      end
      foreach (ws[i]) begin
        if (!ended) begin
          exp.push_back({addr[31:0], ws[i]});
          x ^= xor4(ws[i]);
          if (ws[i] == HALT) begin
            ended = 1;
            mdone = 1;
          end else if (addr == TS - 1) begin
            ended = 1;
            merr  = 1;
          end else begin
            addr++;
          end
        end
      end
      cap.delete();
      pulse_start();
      foreach (ws[i]) send_word(ws[i], $urandom_range(0, 2));
`ifdef LOADER_CHECKSUM_EN
      if (mdone) begin
        logic [7:0] ck;
        ck = $urandom_range(0, 1) ? x : (x ^ 8'($urandom_range(1, 255)));
        send_byte(ck, 0);
        if (ck != x) begin
          mdone = 0;
          merr  = 1;
        end
      end
`endif
      send_byte(8'($urandom), 0);
      send_byte(8'($urandom), 0);
      settle();
      chk("rnd_n", cap.size(), exp.size());
      for (int i = 0; i < exp.size() && i < cap.size(); i++) begin
        chk("rnd_addr", cap[i].a, exp[i].a);
        chk("rnd_data", cap[i].d, exp[i].d);
      end
      chk("rnd_words", wl, exp.size());
      chk("rnd_done", done, mdone);
      chk("rnd_err", err, merr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
